// File: rtl/bc_level_reader.sv
// Streams one level of the box-count pyramid from the box-count RAM in raster order and
// accumulates the non-empty box count and total mass of the accepted beats.
module bc_level_reader #(
  parameter int unsigned BOX_IDX  = 3,
  parameter int unsigned MAX_BOX  = 3,
  parameter int unsigned DATA_LEN = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          start,
  input  logic [BOX_IDX-1:0]            level,
  input  logic                          bank,
  output logic                          busy,
  output logic                          rd_en,
  output logic [2*BOX_IDX:0]            rd_addr,
  input  logic [DATA_LEN-1:0]           rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_LEN-1:0]           out_data,
  output logic [BOX_IDX-1:0]            out_x,
  output logic [BOX_IDX-1:0]            out_y,
  output logic                          out_last,
  output logic [2*BOX_IDX:0]            box_count,
  output logic [DATA_LEN+2*BOX_IDX-1:0] mass_sum,
  output logic                          done
);

  localparam int unsigned AW = 2 * BOX_IDX + 1;
  localparam int unsigned MW = DATA_LEN + 2 * BOX_IDX;
  localparam int unsigned EW = DATA_LEN + 2 * BOX_IDX + 1;

  if (MAX_BOX == 0) begin : g_bad_max_box
    $error("MAX_BOX must be at least 1");
  end

  typedef enum logic {StIdle, StScan} state_t;

  state_t               r_state;
  logic                 r_bank;
  logic [BOX_IDX-1:0]   r_lim;
  logic [BOX_IDX-1:0]   r_x;
  logic [BOX_IDX-1:0]   r_y;
  logic                 r_more;
  logic                 r_rd_vld;
  logic [BOX_IDX-1:0]   r_rd_x;
  logic [BOX_IDX-1:0]   r_rd_y;
  logic                 r_rd_last;
  logic [1:0]           r_cnt;
  logic [EW-1:0]        r_head;
  logic [EW-1:0]        r_tail;
  logic [AW-1:0]        r_box;
  logic [MW-1:0]        r_mass;
  logic                 r_done;

  logic [BOX_IDX-1:0]   w_lvl;
  logic [BOX_IDX-1:0]   w_lim;
  logic [2:0]           w_fill;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_issue;
  logic                 w_last_xy;
  logic [EW-1:0]        w_new;

  // Levels beyond the grid collapse to a single box.
  assign w_lvl     = (level > BOX_IDX'(BOX_IDX)) ? BOX_IDX'(BOX_IDX) : level;
  assign w_lim     = {BOX_IDX{1'b1}} >> w_lvl;

  assign out_valid = (r_cnt != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = r_rd_vld;
  // Entries already committed to the FIFO path, net of this cycle's pop.
  assign w_fill    = {1'b0, r_cnt} + {2'b00, r_rd_vld} - {2'b00, w_pop};
  assign w_issue   = (r_state == StScan) & r_more & (w_fill < 3'd2);
  assign w_last_xy = (r_x == r_lim) & (r_y == r_lim);
  assign w_new     = {rd_data, r_rd_x, r_rd_y, r_rd_last};

  assign busy      = (r_state == StScan);
  assign rd_en     = w_issue;
  assign rd_addr   = {r_x, r_bank, r_y};
  assign out_data  = r_head[EW-1 -: DATA_LEN];
  assign out_x     = r_head[2*BOX_IDX -: BOX_IDX];
  assign out_y     = r_head[BOX_IDX:1];
  assign out_last  = out_valid & r_head[0];
  assign box_count = r_box;
  assign mass_sum  = r_mass;
  assign done      = r_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= StIdle;
      r_bank    <= 1'b0;
      r_lim     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_more    <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_x    <= '0;
      r_rd_y    <= '0;
      r_rd_last <= 1'b0;
      r_cnt     <= 2'd0;
      r_head    <= '0;
      r_tail    <= '0;
      r_box     <= '0;
      r_mass    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_rd_vld <= w_issue;

      if (w_issue) begin
        r_rd_x    <= r_x;
        r_rd_y    <= r_y;
        r_rd_last <= w_last_xy;
        // The final coordinate is kept so rd_addr holds its last value.
        if (w_last_xy) begin
          r_more <= 1'b0;
        end else if (r_x == r_lim) begin
          r_x <= '0;
          r_y <= r_y + BOX_IDX'(1);
        end else begin
          r_x <= r_x + BOX_IDX'(1);
        end
      end

      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= w_new;
          else               r_tail <= w_new;
        end
        2'b01: r_head <= r_tail;
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_head <= w_new;
          end else begin
            r_head <= r_tail;
            r_tail <= w_new;
          end
        end
        default: ;
      endcase
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};

      if (w_pop) begin
        r_mass <= r_mass + MW'(out_data);
        if (out_data != '0) r_box <= r_box + AW'(1);
        if (r_head[0]) begin
          r_state <= StIdle;
          r_done  <= 1'b1;
        end
      end

      if (r_state == StIdle && start) begin
        r_state <= StScan;
        r_bank  <= bank;
        r_lim   <= w_lim;
        r_x     <= '0;
        r_y     <= '0;
        r_more  <= 1'b1;
        r_box   <= '0;
        r_mass  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bc_level_reader.sv
// Randomized bench for bc_level_reader: a RAM model feeds the DUT and every scan is checked
// against an expected beat list and statistics built directly from the grid contents.
module tb_bc_level_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [2:0]  level;
  logic        bank;
  logic        busy;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_x;
  logic [2:0]  out_y;
  logic        out_last;
  logic [6:0]  box_count;
  logic [13:0] mass_sum;
  logic        done;

  logic [7:0]  mem [128];

  int n_chk = 0;
  int n_err = 0;
  int q_d[$], q_x[$], q_y[$], q_l[$], q_a[$];

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (rd_en) rd_data <= mem[rd_addr];

  bc_level_reader #(.BOX_IDX(3), .MAX_BOX(3), .DATA_LEN(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .level(level), .bank(bank), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .out_last(out_last), .box_count(box_count), .mass_sum(mass_sum), .done(done)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, rd_en, rd_addr, out_valid, out_data, out_x, out_y, out_last,
                box_count, mass_sum, done});
  endfunction

  task automatic do_abort();
    RST = 1'b1;
    start = 1'b0;
    #1;
    chk_eq("rst_outs_zero", all_outs(), 64'd0);
    repeat (3) begin
      @(negedge CLK);
      chk_eq("rst_no_done", 64'(done), 64'd0);
    end
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      #1;
      chk_eq("post_rst_idle", all_outs(), 64'd0);
    end
  endtask

  task automatic run_scan(input int lvl, input int bnk, input int rdy_pct, input int abort_at,
                          input bit restart, output int got_box, output int got_mass);
    int l_eff, s, beats, issued, max_out, first_v, exp_box, exp_mass, k;
    bit seen_done, stall_prev;
    logic [63:0] prev;
    l_eff = (lvl > 3) ? 3 : lvl;
    s = 1 << (3 - l_eff);
    q_d.delete(); q_x.delete(); q_y.delete(); q_l.delete(); q_a.delete();
    exp_box = 0;
    exp_mass = 0;
    for (int y = 0; y < s; y++) begin
      for (int x = 0; x < s; x++) begin
        int a;
        a = x * 16 + bnk * 8 + y;
        q_a.push_back(a);
        q_d.push_back(int'(mem[a]));
        q_x.push_back(x);
        q_y.push_back(y);
        q_l.push_back((x == s - 1 && y == s - 1) ? 1 : 0);
        exp_mass += int'(mem[a]);
        if (mem[a] != 8'd0) exp_box++;
      end
    end
    beats = 0; issued = 0; max_out = 0; first_v = 0;
    seen_done = 1'b0; stall_prev = 1'b0; prev = '0;
    got_box = 0; got_mass = 0;

    @(negedge CLK);
    start = 1'b1;
    level = 3'(lvl);
    bank = 1'(bnk);
    out_ready = ($urandom_range(99) < rdy_pct);
    k = 0;
    while (!seen_done && k < 3000) begin
      k++;
      @(negedge CLK);
      start = restart && (k == 5);
      level = 3'($urandom);
      bank = 1'($urandom);
      out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (k == 1) begin
        chk_eq("c1_busy", 64'(busy), 64'd1);
        chk_eq("c1_rd_en", 64'(rd_en), 64'd1);
      end
      if (out_valid && first_v == 0) first_v = k;
      if (stall_prev)
        chk_eq("stall_stable", 64'({out_valid, out_data, out_x, out_y, out_last}), prev);
      if (issued - beats > max_out) max_out = issued - beats;
      if (rd_en) begin
        if (q_a.size() > 0) chk_eq("rd_addr", 64'(rd_addr), 64'(q_a.pop_front()));
        else chk_eq("rd_extra", 64'(issued + 1), 64'(s * s));
        issued++;
      end
      if (done) begin
        seen_done = 1'b1;
        chk_eq("done_busy", 64'(busy), 64'd0);
        chk_eq("box_count", 64'(box_count), 64'(exp_box));
        chk_eq("mass_sum", 64'(mass_sum), 64'(exp_mass));
        chk_eq("beat_total", 64'(beats), 64'(s * s));
        if (rdy_pct >= 100) chk_eq("done_cycle", 64'(k), 64'(s * s + 3));
        got_box = int'(box_count);
        got_mass = int'(mass_sum);
      end
      if (out_valid && out_ready) begin
        if (q_d.size() > 0) begin
          chk_eq("beat_data", 64'(out_data), 64'(q_d.pop_front()));
          chk_eq("beat_x", 64'(out_x), 64'(q_x.pop_front()));
          chk_eq("beat_y", 64'(out_y), 64'(q_y.pop_front()));
          chk_eq("beat_last", 64'(out_last), 64'(q_l.pop_front()));
        end else begin
          chk_eq("beat_extra", 64'(beats + 1), 64'(s * s));
        end
        beats++;
      end
      stall_prev = out_valid && !out_ready;
      prev = 64'({out_valid, out_data, out_x, out_y, out_last});
      if (abort_at > 0 && beats == abort_at) begin
        do_abort();
        return;
      end
    end
    chk_eq("done_seen", 64'(seen_done), 64'd1);
    chk_eq("first_valid_cycle", 64'(first_v), 64'd3);
    chk_eq("outstanding_le2", 64'(max_out <= 2), 64'd1);
    @(negedge CLK);
    #1;
    chk_eq("done_one_cycle", 64'(done), 64'd0);
    chk_eq("stats_hold", 64'({box_count, mass_sum}), 64'({7'(exp_box), 14'(exp_mass)}));
  endtask

  initial begin
    int b, m;
    RST = 1'b1;
    start = 1'b0;
    level = '0;
    bank = 1'b0;
    out_ready = 1'b0;
    for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
    repeat (2) @(negedge CLK);
    chk_eq("reset_outs", all_outs(), 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    #1;
    chk_eq("idle_outs", all_outs(), 64'd0);

    // Full grid of ones in bank 0.
    for (int a = 0; a < 128; a++) if (((a >> 3) & 1) == 0) mem[a] = 8'd1;
    run_scan(0, 0, 100, 0, 1'b0, b, m);
    chk_eq("full_box", 64'(b), 64'd64);
    chk_eq("full_mass", 64'(m), 64'd64);

    // 2x2 region in the reduced bank.
    mem[8'h08] = 8'd0;
    mem[8'h18] = 8'd5;
    mem[8'h09] = 8'd0;
    mem[8'h19] = 8'd255;
    run_scan(2, 1, 100, 0, 1'b0, b, m);
    chk_eq("l2_box", 64'(b), 64'd2);
    chk_eq("l2_mass", 64'(m), 64'd260);

    // Single-box levels, including a clamped one.
    mem[0] = 8'hAB;
    run_scan(3, 0, 100, 0, 1'b0, b, m);
    chk_eq("l3_box", 64'(b), 64'd1);
    chk_eq("l3_mass", 64'(m), 64'd171);
    run_scan(5, 0, 100, 0, 1'b0, b, m);
    chk_eq("l5_box", 64'(b), 64'd1);
    chk_eq("l5_mass", 64'(m), 64'd171);

    // Sparse random contents with random back-pressure.
    for (int a = 0; a < 128; a++) mem[a] = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
    run_scan(1, int'($urandom_range(1)), 50, 0, 1'b0, b, m);

    // Ignored restart, then abort at beat 20 and a clean rescan.
    run_scan(0, 0, 100, 20, 1'b1, b, m);
    run_scan(0, 1, 60, 0, 1'b0, b, m);

    for (int i = 0; i < 6; i++) begin
      for (int a = 0; a < 128; a++) mem[a] = ($urandom_range(2) == 0) ? 8'd0 : 8'($urandom);
      run_scan(int'($urandom_range(7)), int'($urandom_range(1)), int'($urandom_range(30, 100)),
               0, 1'b0, b, m);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bc_level_reader.md
# bc_level_reader

Reads one level of the box-count pyramid out of the box-count RAM, after the 2×2 reduction stage has written it. Scans the selected square region in raster order and streams each box value out on a valid/ready interface. Accumulates the two per-level statistics needed downstream for multifractal analysis: the number of non-empty boxes and the total mass. It is the read-side counterpart of the reduction stage and shares its RAM address layout.

## Interface
Parameters:
- BOX_IDX, 3, log2 of the full grid side; the grid is 2^BOX_IDX × 2^BOX_IDX
- MAX_BOX, 3, largest supported box exponent; kept for parameter compatibility, not used in logic
- DATA_LEN, 8, width of one box value

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to scan a level
- level  in  BOX_IDX  level L; the scanned region side is S = 2^(BOX_IDX−L)
- bank  in  1  RAM half to read; 0 = input grid, 1 = reduced grid
- busy  out  1  high while a scan is in progress
- rd_en  out  1  RAM read strobe
- rd_addr  out  2*BOX_IDX+1  RAM address = {x[BOX_IDX-1:0], bank, y[BOX_IDX-1:0]}
- rd_data  in  DATA_LEN  RAM data; valid exactly 1 cycle after rd_en
- out_valid  out  1  stream beat valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_LEN  box value
- out_x, out_y  out  BOX_IDX each  coordinates of the box
- out_last  out  1  high on the final beat of the level
- box_count  out  2*BOX_IDX+1  count of accepted beats with out_data ≠ 0
- mass_sum  out  DATA_LEN+2*BOX_IDX  sum of accepted out_data
- done  out  1  one-cycle pulse at the end of a scan

## Operation
- FSM has two states, IDLE and SCAN.
- IDLE → SCAN on start:
  - Latches level and bank. A level value greater than BOX_IDX is clamped to BOX_IDX, giving S = 1.
  - Clears box_count and mass_sum, and sets the scan coordinates x = y = 0.
- start while busy is ignored. It does not change the latched parameters.
- Scan order: y is the outer loop and x the inner loop, each running from 0 to S−1. Total S² reads.
- Address generator issues one read per cycle when there is credit.
  - Credit rule: an issue is allowed when (fifo_occupancy + reads_in_flight − pop_this_cycle) < 2.
  - Under this rule, the internal 2-entry output FIFO can never overflow.
- Each returned rd_data is pushed into the FIFO together with its x, y and last flag.
- A handshake occurs when out_valid and out_ready are both high. It pops the FIFO and updates the statistics:
  - mass_sum += out_data.
  - box_count += 1 if out_data ≠ 0.
- Statistic arithmetic is unsigned. The widths are exact for S² × (2^DATA_LEN − 1), so the accumulators cannot overflow.
- SCAN → IDLE on the handshake of the out_last beat.
- box_count and mass_sum hold their final values until the next accepted start.
- rd_addr holds its last value when rd_en is low.

## Timing
- Reset values of outputs:
  - busy, rd_en, out_valid, out_last and done are 0.
  - rd_addr, out_data, out_x, out_y, box_count and mass_sum are 0.
  - The FIFO and the in-flight tracking are emptied.
- start is sampled at edge 0. busy and the first rd_en are high in cycle 1, with rd_addr = {0, bank, 0}.
- rd_data arrives in cycle 2. out_valid rises in cycle 3, so start-to-first-beat latency is 3 cycles.
- With out_ready held high, there is one beat per cycle and no bubbles.
- For the final beat, done = 1 and busy = 0 in the cycle after its handshake. The statistics are final in that same cycle.
- out_valid low with out_ready high: no effect.
- Under back-pressure, out_data, out_x, out_y and out_last stay stable while out_valid is high and out_ready is low.
- RST asserted mid-scan aborts the scan immediately:
  - In-flight RAM data is discarded.
  - done is not pulsed.
  - The statistics clear to 0.

## Test plan
- level=0, bank=0, all 64 cells = 1, out_ready=1, start at edge 0:
  - First out_valid in cycle 3; 64 beats in raster order, y outer.
  - out_last on (x=7, y=7).
  - done in cycle 67; box_count=64, mass_sum=64.
- level=2, bank=1, RAM values (x,y)=(0,0):0, (1,0):5, (0,1):0, (1,1):255:
  - rd_addr sequence 0x08, 0x18, 0x09, 0x19.
  - 4 beats; box_count=2, mass_sum=260.
- level=3 and level=5 (clamped), cell value 0xAB:
  - A single beat with out_last=1 and out_data=0xAB.
  - box_count=1, mass_sum=171.
- level=1, random out_ready (50%):
  - All 16 values are delivered exactly once, in order, and stay stable while stalled.
  - reads_in_flight + occupancy never exceeds 2.
  - Statistics match a reference sum.
- start pulsed again during a level=0 scan, then RST at beat 20:
  - The second start has no effect.
  - After RST, all outputs are 0 and no done pulse occurs.
  - A new start gives a correct full scan.
